alu_exec_unit: RTL and testbench

//  Parametrised multi-cycle ALU execution unit with internal register file and latched flags.

---
 rtl/alu_exec_unit.sv | 222 ++++++++++++++++++++++
 tb/tb_alu_exec_unit.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// Multi-cycle ALU execution unit with an internal register file and latched Z/N/C flags.
// Optional signed-overflow flag V is built only when ALU_OVERFLOW_FLAG_EN is defined.
module alu_exec_unit #(
    parameter int DATA_WIDTH  = 8,
    parameter int NUM_REGS    = 4,
    parameter int EXEC_CYCLES = 2,
    localparam int RW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic [3:0]            op_i,
    input  logic [RW-1:0]         dst_sel_i,
    input  logic [RW-1:0]         src_sel_i,
    input  logic                  load_en_i,
    input  logic [DATA_WIDTH-1:0] load_data_i,
    input  logic [RW-1:0]         rd_sel_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic [DATA_WIDTH-1:0] a_out,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  flag_zero_o,
    output logic                  flag_negative_o,
    output logic                  flag_carry_o,
    output logic                  flag_overflow_o
);
    localparam int CW = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(EXEC_CYCLES - 1);
    localparam int MSB = DATA_WIDTH - 1;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_ADC = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_SBB = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4;
    localparam logic [3:0] OP_OR  = 4'd5;
    localparam logic [3:0] OP_XOR = 4'd6;
    localparam logic [3:0] OP_INC = 4'd7;
    localparam logic [3:0] OP_DEC = 4'd8;
    localparam logic [3:0] OP_CMP = 4'd9;
    localparam logic [3:0] OP_NOT = 4'd10;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_LATCH} state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [3:0]              op_q, op_d;
    logic [RW-1:0]           dst_q, dst_d;
    logic [DATA_WIDTH-1:0]   opa_q, opa_d, opb_q, opb_d;
    logic                    cin_q, cin_d;
    logic [DATA_WIDTH-1:0]   regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0]   regs_d [NUM_REGS];
    logic                    z_q, z_d, n_q, n_d, c_q, c_d;
    logic                    busy_q, busy_d, done_q, done_d;

    logic [DATA_WIDTH:0]     ext_s;
    logic [DATA_WIDTH-1:0]   alu_r_s;
    logic                    alu_c_s, alu_upd_s, alu_wr_s;

    // Result computed from the operands captured at issue; bit DATA_WIDTH is carry/borrow.
    always_comb begin
        ext_s     = '0;
        alu_upd_s = 1'b1;
        alu_wr_s  = 1'b1;
        case (op_q)
            OP_ADD: ext_s = {1'b0, opa_q} + {1'b0, opb_q};
            OP_ADC: ext_s = {1'b0, opa_q} + {1'b0, opb_q} + {{DATA_WIDTH{1'b0}}, cin_q};
            OP_SUB: ext_s = {1'b0, opa_q} - {1'b0, opb_q};
            OP_SBB: ext_s = {1'b0, opa_q} - {1'b0, opb_q} - {{DATA_WIDTH{1'b0}}, cin_q};
            OP_AND: ext_s = {1'b0, opa_q & opb_q};
            OP_OR:  ext_s = {1'b0, opa_q | opb_q};
            OP_XOR: ext_s = {1'b0, opa_q ^ opb_q};
            OP_INC: ext_s = {1'b0, opa_q} + {{DATA_WIDTH{1'b0}}, 1'b1};
            OP_DEC: ext_s = {1'b0, opa_q} - {{DATA_WIDTH{1'b0}}, 1'b1};
            OP_CMP: begin
                ext_s    = {1'b0, opa_q} - {1'b0, opb_q};
                alu_wr_s = 1'b0;
            end
            OP_NOT: ext_s = {1'b0, ~opa_q};
            default: begin
                alu_upd_s = 1'b0;
                alu_wr_s  = 1'b0;
            end
        endcase
        alu_r_s = ext_s[DATA_WIDTH-1:0];
        alu_c_s = ext_s[DATA_WIDTH];
    end

`ifdef ALU_OVERFLOW_FLAG_EN
    logic v_q, v_d, alu_v_s;

    // Signed overflow: INC/DEC behave as add/sub of +1, logic ops clear V.
    always_comb begin
        case (op_q)
            OP_ADD, OP_ADC:         alu_v_s = (opa_q[MSB] == opb_q[MSB]) && (alu_r_s[MSB] != opa_q[MSB]);
            OP_SUB, OP_SBB, OP_CMP: alu_v_s = (opa_q[MSB] != opb_q[MSB]) && (alu_r_s[MSB] != opa_q[MSB]);
            OP_INC:                 alu_v_s = ~opa_q[MSB] & alu_r_s[MSB];
            OP_DEC:                 alu_v_s = opa_q[MSB] & ~alu_r_s[MSB];
            default:                alu_v_s = 1'b0;
        endcase
    end
`endif

    // Next-state: FSM sequencing, operand capture, immediate load and result latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        dst_d   = dst_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        cin_d   = cin_q;
        regs_d  = regs_q;
        z_d     = z_q;
        n_d     = n_q;
        c_d     = c_q;
        done_d  = 1'b0;
`ifdef ALU_OVERFLOW_FLAG_EN
        v_d     = v_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_EXEC;
                    cnt_d   = '0;
                    op_d    = op_i;
                    dst_d   = dst_sel_i;
                    opa_d   = regs_q[dst_sel_i];
                    opb_d   = regs_q[src_sel_i];
                    cin_d   = c_q;
                end else if (load_en_i) begin
                    regs_d[dst_sel_i] = load_data_i;
                    z_d = (load_data_i == '0);
                    n_d = load_data_i[MSB];
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_EXEC: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = S_LATCH;
                end else begin
                    cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                end
            end
            S_LATCH: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                if (alu_upd_s) begin
                    z_d = (alu_r_s == '0);
                    n_d = alu_r_s[MSB];
                    c_d = alu_c_s;
`ifdef ALU_OVERFLOW_FLAG_EN
                    v_d = alu_v_s;
`endif
                    if (alu_wr_s) begin
                        regs_d[dst_q] = alu_r_s;
                    end else begin
                        regs_d[dst_q] = regs_q[dst_q];
                    end
                end else begin
                    z_d = z_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State, datapath and flag registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= 4'd0;
            dst_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            cin_q   <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
            z_q     <= 1'b0;
            n_q     <= 1'b0;
            c_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef ALU_OVERFLOW_FLAG_EN
            v_q     <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            dst_q   <= dst_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            cin_q   <= cin_d;
            regs_q  <= regs_d;
            z_q     <= z_d;
            n_q     <= n_d;
            c_q     <= c_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef ALU_OVERFLOW_FLAG_EN
            v_q     <= v_d;
`endif
        end
    end

    assign rd_data_o       = regs_q[rd_sel_i];
    assign a_out           = regs_q[0];
    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign flag_zero_o     = z_q;
    assign flag_negative_o = n_q;
    assign flag_carry_o    = c_q;
`ifdef ALU_OVERFLOW_FLAG_EN
    assign flag_overflow_o = v_q;
`else
    assign flag_overflow_o = 1'b0;
`endif

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: directed ops push expected results, a monitor checks on done_o.
module tb_alu_exec_unit;
    localparam int DW = 8;
    localparam int NR = 4;
    localparam int EC = 2;
`ifdef ALU_OVERFLOW_FLAG_EN
    localparam logic VEN = 1'b1;
`else
    localparam logic VEN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset, start_i, load_en_i;
    logic [3:0]    op_i;
    logic [1:0]    dst_sel_i, src_sel_i, rd_sel_i;
    logic [DW-1:0] load_data_i, rd_data_o, a_out;
    logic          busy_o, done_o, flag_zero_o, flag_negative_o, flag_carry_o, flag_overflow_o;
    logic [3:0]    flg_s;

    assign flg_s = {flag_zero_o, flag_negative_o, flag_carry_o, flag_overflow_o};

    always #5 clk = ~clk;

    alu_exec_unit #(.DATA_WIDTH(DW), .NUM_REGS(NR), .EXEC_CYCLES(EC)) dut (
        .clk(clk), .reset(reset), .start_i(start_i), .op_i(op_i),
        .dst_sel_i(dst_sel_i), .src_sel_i(src_sel_i),
        .load_en_i(load_en_i), .load_data_i(load_data_i),
        .rd_sel_i(rd_sel_i), .rd_data_o(rd_data_o), .a_out(a_out),
        .busy_o(busy_o), .done_o(done_o),
        .flag_zero_o(flag_zero_o), .flag_negative_o(flag_negative_o),
        .flag_carry_o(flag_carry_o), .flag_overflow_o(flag_overflow_o)
    );

    typedef struct {
        logic [DW-1:0] val;
        logic [3:0]    flg;
        int            cyc;
        string         name;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    // Monitor: on each done pulse, pop the oldest expectation and compare.
    always @(posedge clk) begin
        #1;
        if (done_o === 1'b1) begin
            chk("done_expected", (exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                chk({mon_e.name, "_val"}, rd_data_o, mon_e.val);
                chk({mon_e.name, "_flags"}, flg_s, mon_e.flg);
                chk({mon_e.name, "_latency"}, cyc, mon_e.cyc + EC + 2);
                chk({mon_e.name, "_busy_low"}, busy_o, 0);
            end
        end
    end

    task automatic load(input logic [1:0] d, input logic [DW-1:0] v);
        load_en_i = 1'b1; dst_sel_i = d; load_data_i = v; rd_sel_i = d;
        @(negedge clk);
        load_en_i = 1'b0;
        chk("load_val", rd_data_o, v);
    endtask

    task automatic issue(input logic [3:0] op, input logic [1:0] d, input logic [1:0] s,
                         input logic [DW-1:0] ev, input logic [3:0] ef, input string nm);
        start_i = 1'b1; op_i = op; dst_sel_i = d; src_sel_i = s; rd_sel_i = d;
        exp_q.push_back('{val: ev, flg: ef, cyc: cyc, name: nm});
        @(negedge clk);
        start_i = 1'b0;
        chk({nm, "_busy"}, busy_o, 1);
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (done_o === 1'b1) seen = 1'b1;
        end
        chk("done_timeout", seen, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start_i = 1'b0; load_en_i = 1'b0; op_i = 4'd0;
        dst_sel_i = 2'd0; src_sel_i = 2'd0; rd_sel_i = 2'd0; load_data_i = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_a_out", a_out, 8'h00);
        chk("rst_flags", flg_s, 4'b0000);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        reset = 1'b0;
        @(negedge clk);

        // 1: basic add, N set
        load(2'd0, 8'h01); load(2'd1, 8'hF4);
        issue(4'd0, 2'd0, 2'd1, 8'hF5, 4'b0100, "t1_add");
        wait_done();
        chk("t1_a_out", a_out, 8'hF5);

        // 2: carry out, then back-to-back ADC using it
        load(2'd0, 8'hF0); load(2'd1, 8'h20);
        issue(4'd0, 2'd0, 2'd1, 8'h10, 4'b0010, "t2_add");
        wait_done();
        issue(4'd1, 2'd0, 2'd1, 8'h31, 4'b0000, "t2_adc");
        wait_done();

        // 3: SUB to zero, CMP borrow without write, NOP keeps flags
        load(2'd2, 8'h55); load(2'd3, 8'h55);
        issue(4'd2, 2'd2, 2'd3, 8'h00, 4'b1000, "t3_sub");
        wait_done();
        issue(4'd9, 2'd2, 2'd3, 8'h00, 4'b0110, "t3_cmp");
        wait_done();
        issue(4'd12, 2'd2, 2'd3, 8'h00, 4'b0110, "t3_nop");
        wait_done();

        // 4: start/load while busy ignored; start+load in IDLE -> only op
        load(2'd0, 8'h03); load(2'd1, 8'h04);
        issue(4'd4, 2'd0, 2'd1, 8'h00, 4'b1000, "t4_and");
        start_i = 1'b1; op_i = 4'd0; dst_sel_i = 2'd1; src_sel_i = 2'd1;
        load_en_i = 1'b1; load_data_i = 8'hFF;
        @(negedge clk);
        start_i = 1'b0; load_en_i = 1'b0;
        wait_done();
        chk("t4_a_out", a_out, 8'h00);
        rd_sel_i = 2'd1; #1;
        chk("t4_r1_kept", rd_data_o, 8'h04);
        @(negedge clk);
        load_en_i = 1'b1; load_data_i = 8'h77;
        issue(4'd6, 2'd0, 2'd1, 8'h04, 4'b0000, "t4_xor");
        load_en_i = 1'b0;
        wait_done();
        chk("t4_load_dropped", a_out, 8'h04);

        // remaining ops
        issue(4'd8, 2'd0, 2'd0, 8'h03, 4'b0000, "dec_r0");
        wait_done();
        issue(4'd10, 2'd0, 2'd0, 8'hFC, 4'b0100, "not_r0");
        wait_done();
        load(2'd1, 8'hFF);
        issue(4'd7, 2'd1, 2'd1, 8'h00, 4'b1010, "inc_r1");
        wait_done();
        issue(4'd8, 2'd2, 2'd2, 8'hFF, 4'b0110, "dec_r2");
        wait_done();
        issue(4'd3, 2'd0, 2'd2, 8'hFC, 4'b0110, "sbb_r0");
        wait_done();
        issue(4'd5, 2'd0, 2'd1, 8'hFC, 4'b0100, "or_r0");
        wait_done();

        // 5: reset mid-EXEC
        issue(4'd0, 2'd0, 2'd2, 8'hFB, 4'b0110, "t5_aborted");
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        chk("t5_a_out", a_out, 8'h00);
        chk("t5_flags", flg_s, 4'b0000);
        chk("t5_busy", busy_o, 0);
        chk("t5_done", done_o, 0);
        rd_sel_i = 2'd2; #1;
        chk("t5_r2", rd_data_o, 8'h00);
        repeat (6) @(negedge clk);
        load(2'd0, 8'h05); load(2'd1, 8'h03);
        issue(4'd2, 2'd0, 2'd1, 8'h02, 4'b0000, "t5_sub");
        wait_done();

        // 6: signed overflow
        load(2'd0, 8'h7F); load(2'd1, 8'h01);
        issue(4'd0, 2'd0, 2'd1, 8'h80, {3'b010, VEN}, "t6_add_ovf");
        wait_done();
        load(2'd0, 8'h80);
        issue(4'd2, 2'd0, 2'd1, 8'h7F, {3'b000, VEN}, "t6_sub_ovf");
        wait_done();

        repeat (4) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
